// File: rtl/wb_slave_demux_if.sv
// Wishbone classic bus bundle for wb_slave_demux: the arbitrated master side
// (wbm_*) and the shared/one-hot slave side (wbs_*).
// Signal suffixes are from the demux's point of view.
// The slave modport is the demux itself.
// The master modport is whatever surrounds it: the upstream master plus the slaves.
// Handshake: a request is presented while cyc&stb are high and is held stable until
// the demux answers with a single-cycle ack or err.
// Slaves see cyc/stb high until they return ack or err.
interface wb_slave_demux_if #(
  parameter int NSLAVES = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
);
  logic [AW-1:0]         wbm_adr_i;
  logic [DW-1:0]         wbm_dat_i;
  logic [DW/8-1:0]       wbm_sel_i;
  logic                  wbm_we_i;
  logic                  wbm_stb_i;
  logic                  wbm_cyc_i;
  logic [DW-1:0]         wbm_dat_o;
  logic                  wbm_ack_o;
  logic                  wbm_err_o;
  logic [AW-1:0]         wbs_adr_o;
  logic [DW-1:0]         wbs_dat_o;
  logic [DW/8-1:0]       wbs_sel_o;
  logic                  wbs_we_o;
  logic [NSLAVES-1:0]    wbs_cyc_o;
  logic [NSLAVES-1:0]    wbs_stb_o;
  logic [NSLAVES*DW-1:0] wbs_dat_i;
  logic [NSLAVES-1:0]    wbs_ack_i;
  logic [NSLAVES-1:0]    wbs_err_i;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_stb_i, wbm_cyc_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_stb_i, wbm_cyc_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i
  );
endinterface

// File: rtl/wb_slave_demux.sv
// Wishbone classic 1-master to N-slave address decoder/router.
// Each request is registered and routed to one slave by address window; the
// lowest index wins on overlapping windows. The chosen slave's ack/err/data is
// returned to the master one cycle later. Unmapped addresses terminate with err.
// Optional: define WB_DEMUX_TIMEOUT_EN to terminate silent slaves with err
// after TIMEOUT_CYCLES cycles in ACTIVE.
// dbg_state_o exposes the FSM state (0 IDLE, 1 ACTIVE, 2 RESP, 3 DERR).
module wb_slave_demux #(
  parameter int                    NSLAVES        = 4,
  parameter int                    AW             = 32,
  parameter int                    DW             = 32,
  parameter logic [NSLAVES*AW-1:0] SLAVE_ADDR     = {32'h3000_0000, 32'h2000_0000,
                                                     32'h1000_0000, 32'h0000_0000},
  parameter logic [NSLAVES*AW-1:0] SLAVE_MASK     = {4{32'hF000_0000}},
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  wb_slave_demux_if.slave   bus,
  output logic [1:0]        dbg_state_o
);

  localparam int IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2,
    ST_DERR   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic              we_q, we_d;
  logic [NSLAVES-1:0] cyc_q, cyc_d;
  logic [DW-1:0]     mdat_q, mdat_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

`ifdef WB_DEMUX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]     cnt_q, cnt_d;
`endif

  logic              hit_any;
  logic [IW-1:0]     hit_idx;
  logic              sel_ack;
  logic              sel_err;
  logic [DW-1:0]     sel_dat;

  // Address decode; the loop runs high to low so the lowest matching index wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((SLAVE_MASK[i*AW +: AW] != '0) &&
          ((bus.wbm_adr_i & SLAVE_MASK[i*AW +: AW]) ==
           (SLAVE_ADDR[i*AW +: AW] & SLAVE_MASK[i*AW +: AW]))) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Response from the selected slave only; other slaves' ack/err never reach the FSM.
  always_comb begin
    sel_ack = bus.wbs_ack_i[idx_q];
    sel_err = bus.wbs_err_i[idx_q];
    sel_dat = bus.wbs_dat_i[int'(idx_q)*DW +: DW];
  end

  // Next-state logic; ack/err default low so each is a one-cycle pulse.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    mdat_d  = mdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
`ifdef WB_DEMUX_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
          if (hit_any) begin
            idx_d          = hit_idx;
            adr_d          = bus.wbm_adr_i;
            dat_d          = bus.wbm_dat_i;
            sel_d          = bus.wbm_sel_i;
            we_d           = bus.wbm_we_i;
            cyc_d          = '0;
            cyc_d[hit_idx] = 1'b1;
            state_d        = ST_ACTIVE;
`ifdef WB_DEMUX_TIMEOUT_EN
            cnt_d          = '0;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = ST_DERR;
          end
        end
      end
      ST_ACTIVE: begin
        if (!bus.wbm_cyc_i) begin
          // Master abandoned the cycle: drop the slave silently.
          cyc_d   = '0;
          state_d = ST_IDLE;
        end else if (sel_err) begin
          // err wins over a simultaneous ack and leaves read data untouched.
          err_d   = 1'b1;
          cyc_d   = '0;
          state_d = ST_RESP;
        end else if (sel_ack) begin
          ack_d   = 1'b1;
          mdat_d  = sel_dat;
          cyc_d   = '0;
          state_d = ST_RESP;
        end
`ifdef WB_DEMUX_TIMEOUT_EN
        else if (cnt_q == TW'(TIMEOUT_CYCLES)) begin
          err_d   = 1'b1;
          cyc_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      ST_DERR: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= '0;
      mdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef WB_DEMUX_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      mdat_q  <= mdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
`ifdef WB_DEMUX_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.wbm_dat_o = mdat_q;
  assign bus.wbm_ack_o = ack_q;
  assign bus.wbm_err_o = err_q;
  assign bus.wbs_adr_o = adr_q;
  assign bus.wbs_dat_o = dat_q;
  assign bus.wbs_sel_o = sel_q;
  assign bus.wbs_we_o  = we_q;
  assign bus.wbs_cyc_o = cyc_q;
  assign bus.wbs_stb_o = cyc_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_wb_slave_demux.sv
// Bench for wb_slave_demux: directed transactions with hand-computed expected
// responses pushed to exp_q, and a negedge monitor that pops and compares on every
// master ack/err. Slave-side routing is checked directly by the driver.
module tb_wb_slave_demux;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2 + DW + 32;   // {err, ack, dat, cycle}

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         cyc_no;
  int         total;
  int         bad;
  int         c0;
  logic [W-1:0] exp_q[$];

  wb_slave_demux_if #(.NSLAVES(NS), .AW(AW), .DW(DW)) bus ();

  wb_slave_demux #(.NSLAVES(NS), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc_no - c0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic master_idle();
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
    bus.wbm_we_i  = 1'b0;
  endtask

  task automatic slave_idle();
    bus.wbs_ack_i = '0;
    bus.wbs_err_i = '0;
  endtask

  task automatic req(input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                     input logic [DW/8-1:0] sel, input logic we);
    bus.wbm_adr_i = adr;
    bus.wbm_dat_i = dat;
    bus.wbm_sel_i = sel;
    bus.wbm_we_i  = we;
    bus.wbm_cyc_i = 1'b1;
    bus.wbm_stb_i = 1'b1;
    c0 = cyc_no;
  endtask

  task automatic expect_resp(input logic err, input logic ack, input logic [DW-1:0] dat,
                             input int rel_cycle);
    exp_q.push_back({err, ack, dat, 32'(c0 + rel_cycle)});
  endtask

  // Monitor: invariants every cycle, and scoreboard pop on each master response.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (bus.wbm_ack_o && bus.wbm_err_o) begin
        bad++;
        $display("FAIL ack_err_excl: ack=%b err=%b", bus.wbm_ack_o, bus.wbm_err_o);
      end
      total++;
      if ($countones(bus.wbs_cyc_o) > 1) begin
        bad++;
        $display("FAIL cyc_onehot: wbs_cyc_o=%b", bus.wbs_cyc_o);
      end
      if (bus.wbm_ack_o || bus.wbm_err_o) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        a = {bus.wbm_err_o, bus.wbm_ack_o, bus.wbm_dat_o, 32'(cyc_no)};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp: err=%b ack=%b dat=%h at cycle %0d, none required",
                   a[W-1], a[W-2], a[W-3 -: DW], cyc_no);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            bad++;
            $display("FAIL resp: got err=%b ack=%b dat=%h cyc=%0d, want err=%b ack=%b dat=%h cyc=%0d",
                     a[W-1], a[W-2], a[W-3 -: DW], a[31:0],
                     e[W-1], e[W-2], e[W-3 -: DW], e[31:0]);
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    cyc_no = 0;
    total  = 0;
    bad    = 0;
    c0     = 0;
    rst    = 1'b1;
    bus.wbm_adr_i = '0;
    bus.wbm_dat_i = '0;
    bus.wbm_sel_i = '0;
    master_idle();
    slave_idle();
    bus.wbs_dat_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stb",   64'(bus.wbs_stb_o), 64'h0);
    chk("rst_cyc",   64'(bus.wbs_cyc_o), 64'h0);
    chk("rst_ackerr", 64'({bus.wbm_ack_o, bus.wbm_err_o}), 64'h0);
    chk("rst_mdat",  64'(bus.wbm_dat_o), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'h0);
    tick();
    rst = 1'b0;

    // 1: read slave1, ack on first stb cycle
    tick();
    req(32'h1000_0010, 32'h0, 4'hF, 1'b0);
    expect_resp(1'b0, 1'b1, 32'hDEAD_BEEF, 2);
    @(negedge clk);
    chk("t1_c0_stb", 64'(bus.wbs_stb_o), 64'h0);
    tick();
    bus.wbs_dat_i[1*DW +: DW] = 32'hDEAD_BEEF;
    bus.wbs_ack_i = 4'b0010;
    @(negedge clk);
    chk("t1_c1_stb", 64'(bus.wbs_stb_o), 64'h2);
    chk("t1_c1_cyc", 64'(bus.wbs_cyc_o), 64'h2);
    chk("t1_c1_adr", 64'(bus.wbs_adr_o), 64'h1000_0010);
    chk("t1_c1_we",  64'(bus.wbs_we_o), 64'h0);
    tick();
    slave_idle();
    @(negedge clk);
    chk("t1_c2_stb", 64'(bus.wbs_stb_o), 64'h0);
    tick();
    master_idle();
    repeat (2) tick();

    // 2: write slave2, three wait cycles then ack at cycle 4
    tick();
    req(32'h2000_0004, 32'h1234_5678, 4'b0011, 1'b1);
    expect_resp(1'b0, 1'b1, 32'hCAFE_0002, 5);
    bus.wbs_dat_i[2*DW +: DW] = 32'hCAFE_0002;
    tick();
    @(negedge clk);
    chk("t2_c1_stb", 64'(bus.wbs_stb_o), 64'h4);
    chk("t2_c1_we",  64'(bus.wbs_we_o), 64'h1);
    chk("t2_c1_dat", 64'(bus.wbs_dat_o), 64'h1234_5678);
    chk("t2_c1_sel", 64'(bus.wbs_sel_o), 64'h3);
    chk("t2_c1_adr", 64'(bus.wbs_adr_o), 64'h2000_0004);
    repeat (3) tick();
    bus.wbs_ack_i = 4'b0100;
    @(negedge clk);
    chk("t2_c4_stb", 64'(bus.wbs_stb_o), 64'h4);
    tick();
    slave_idle();
    @(negedge clk);
    chk("t2_c5_stb", 64'(bus.wbs_stb_o), 64'h0);
    tick();
    master_idle();
    repeat (2) tick();

    // 3: unmapped read terminates with err, data unchanged
    tick();
    req(32'h5000_0000, 32'h0, 4'hF, 1'b0);
    expect_resp(1'b1, 1'b0, 32'hCAFE_0002, 1);
    tick();
    @(negedge clk);
    chk("t3_c1_stb", 64'(bus.wbs_stb_o), 64'h0);
    chk("t3_c1_state", 64'(dbg_state), 64'h3);
    tick();
    master_idle();
    @(negedge clk);
    chk("t3_c2_err", 64'(bus.wbm_err_o), 64'h0);
    repeat (2) tick();

    // 4: slave0; spurious slave3 ack alone, then ack+err together (plus slave3 again)
    tick();
    req(32'h0000_0100, 32'h0, 4'hF, 1'b0);
    expect_resp(1'b1, 1'b0, 32'hCAFE_0002, 3);
    bus.wbs_dat_i[0*DW +: DW] = 32'h1111_1111;
    bus.wbs_dat_i[3*DW +: DW] = 32'h3333_3333;
    tick();
    bus.wbs_ack_i = 4'b1000;
    @(negedge clk);
    chk("t4_c1_stb", 64'(bus.wbs_stb_o), 64'h1);
    tick();
    bus.wbs_ack_i = 4'b1001;
    bus.wbs_err_i = 4'b0001;
    @(negedge clk);
    chk("t4_c2_stb", 64'(bus.wbs_stb_o), 64'h1);
    tick();
    slave_idle();
    @(negedge clk);
    chk("t4_c3_stb", 64'(bus.wbs_stb_o), 64'h0);
    tick();
    master_idle();
    repeat (2) tick();

    // 5: master drops cyc two cycles into ACTIVE -> silent abort
    tick();
    req(32'h3000_0000, 32'h0, 4'hF, 1'b0);
    tick();
    @(negedge clk);
    chk("t5_c1_stb", 64'(bus.wbs_stb_o), 64'h8);
    tick();
    master_idle();
    @(negedge clk);
    chk("t5_c2_stb", 64'(bus.wbs_stb_o), 64'h8);
    tick();
    @(negedge clk);
    chk("t5_c3_stb", 64'(bus.wbs_stb_o), 64'h0);
    chk("t5_c3_state", 64'(dbg_state), 64'h0);
    chk("t5_c3_mdat", 64'(bus.wbm_dat_o), 64'hCAFE_0002);
    repeat (3) tick();

    // 6: reset pulsed mid-ACTIVE -> slave cyc/stb drop at once, no response
    tick();
    req(32'h1000_0000, 32'h0, 4'hF, 1'b0);
    tick();
    @(negedge clk);
    chk("t6_c1_stb", 64'(bus.wbs_stb_o), 64'h2);
    tick();
    rst = 1'b1;
    master_idle();
    #1;
    chk("t6_rst_stb",  64'(bus.wbs_stb_o), 64'h0);
    chk("t6_rst_cyc",  64'(bus.wbs_cyc_o), 64'h0);
    chk("t6_rst_ack",  64'({bus.wbm_ack_o, bus.wbm_err_o}), 64'h0);
    chk("t6_rst_mdat", 64'(bus.wbm_dat_o), 64'h0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();

    // 7: silent slave2
    tick();
    req(32'h2000_0000, 32'h0, 4'hF, 1'b0);
`ifdef WB_DEMUX_TIMEOUT_EN
    expect_resp(1'b1, 1'b0, 32'h0, 10);
    repeat (9) tick();
    @(negedge clk);
    chk("t7_c9_stb", 64'(bus.wbs_stb_o), 64'h4);
    tick();
    @(negedge clk);
    chk("t7_c10_stb", 64'(bus.wbs_stb_o), 64'h0);
    tick();
    master_idle();
`else
    repeat (1000) tick();
    @(negedge clk);
    chk("t7_c1000_stb", 64'(bus.wbs_stb_o), 64'h4);
    chk("t7_c1000_state", 64'(dbg_state), 64'h1);
    tick();
    master_idle();
    tick();
    @(negedge clk);
    chk("t7_abort_stb", 64'(bus.wbs_stb_o), 64'h0);
`endif
    repeat (4) tick();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_resp: %0d responses outstanding, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_slave_demux.md
Name: wb_slave_demux

Overview:
- Wishbone classic 1-master-to-N-slave address decoder/router; the slave-side counterpart of the multi-master arbitration stage.
- Sits between the arbitrated bus master port and the peripheral/memory slaves.
- Registers each request, routes it to exactly one slave by address window, and returns that slave's ack/err/data to the master.
- Unmapped addresses terminate with err.

Parameters:
NSLAVES, 4, number of slave ports (1..16)
AW, 32, address width
DW, 32, data width (multiple of 8)
SLAVE_ADDR, {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}, base address per slave; slave i at bits [i*AW +: AW]
SLAVE_MASK, {4{32'hF000_0000}}, compare mask per slave, same packing; all-zero mask = slave disabled
TIMEOUT_CYCLES, 255, slave response timeout (used only with WB_DEMUX_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
wbm_adr_i  input  AW  master address
wbm_dat_i  input  DW  master write data
wbm_sel_i  input  DW/8  byte selects
wbm_we_i  input  1  write enable
wbm_stb_i  input  1  strobe
wbm_cyc_i  input  1  cycle
wbm_dat_o  output  DW  read data to master
wbm_ack_o  output  1  ack to master
wbm_err_o  output  1  err to master
wbs_adr_o  output  AW  registered address, shared by all slaves
wbs_dat_o  output  DW  registered write data, shared
wbs_sel_o  output  DW/8  registered byte selects, shared
wbs_we_o  output  1  registered write enable, shared
wbs_cyc_o  output  NSLAVES  one-hot cycle per slave
wbs_stb_o  output  NSLAVES  one-hot strobe per slave
wbs_dat_i  input  NSLAVES*DW  slave read data; slave i at [i*DW +: DW]
wbs_ack_i  input  NSLAVES  slave acks
wbs_err_i  input  NSLAVES  slave errs

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0, including wbs_cyc_o/wbs_stb_o and wbm_dat_o. Reset mid-transaction drops slave cyc/stb immediately, with no ack to the master.
- Decode: hit[i] = (mask[i] != 0) && ((wbm_adr_i & mask[i]) == (SLAVE_ADDR[i] & mask[i])). On overlapping windows the lowest index wins.
- FSM states: IDLE, ACTIVE, RESP, DERR.
- IDLE, when cyc&stb with a hit:
  - Latch idx, adr, dat, sel, we.
  - Next cycle enter ACTIVE with wbs_cyc_o[idx]=wbs_stb_o[idx]=1; all other bits 0.
- IDLE, when cyc&stb with no hit: enter DERR. wbm_err_o=1 for exactly one cycle, then IDLE.
- ACTIVE:
  - Hold slave signals until wbs_ack_i[idx] or wbs_err_i[idx].
  - On that cycle: capture wbs_dat_i[idx] into wbm_dat_o (ack only; on err wbm_dat_o is unchanged) and enter RESP.
  - Slave cyc/stb deassert on the transition into RESP.
- RESP: wbm_ack_o (or wbm_err_o) high for exactly one cycle, then IDLE.
- Simultaneous ack and err from the selected slave: err wins, data not captured.
- Ack/err from non-selected slaves is ignored in every state.
- Master drops wbm_cyc_i during ACTIVE: abort. Next cycle slave cyc/stb = 0, state IDLE, no master ack/err, wbm_dat_o unchanged.
- Latency:
  - Request accepted at cycle 0 -> slave stb at cycle 1.
  - Slave ack at cycle k -> wbm_ack_o at cycle k+1.
  - Minimum round trip is 3 cycles (slave ack in same cycle as stb).
- The master holds stb/cyc and request fields stable until ack/err (classic Wishbone). One outstanding transaction; new requests are sampled only in IDLE.
- wbm_ack_o and wbm_err_o are never high together. At most one wbs_cyc_o bit is ever high.

Optional Feature:
- WB_DEMUX_TIMEOUT_EN defined:
  - $clog2(TIMEOUT_CYCLES+1)-bit counter cleared on entry to ACTIVE, incremented each ACTIVE cycle.
  - If it reaches TIMEOUT_CYCLES without ack/err: deassert slave cyc/stb, enter RESP with wbm_err_o=1.
  - A response arriving on the expiry cycle takes precedence over the timeout.
- Undefined: no counter; ACTIVE waits indefinitely; TIMEOUT_CYCLES ignored.

Test Plan:
- Read adr 32'h1000_0010, slave1 acks on its first stb cycle with dat 32'hDEAD_BEEF -> wbs_stb_o=4'b0010 at cycle 1; wbm_ack_o=1, wbm_dat_o=32'hDEAD_BEEF at cycle 2; all stb 0 at cycle 2.
- Write adr 32'h2000_0004, dat 32'h1234_5678, sel 4'b0011, slave2 acks after 3 wait cycles -> wbs_we_o=1, wbs_dat_o/sel_o match; wbm_ack_o at cycle 5 only.
- Read adr 32'h5000_0000 (unmapped) -> no wbs_stb_o bit set; wbm_err_o=1 at cycle 1 for one cycle; wbm_dat_o unchanged.
- Slave0 asserts ack and err together; slave3 asserts a spurious ack -> wbm_err_o=1, wbm_ack_o=0, slave3 ack ignored.
- wbm_cyc_i dropped 2 cycles into ACTIVE; separately, rst pulsed mid-ACTIVE -> abort: slave cyc/stb 0 next cycle, no ack. Reset: slave cyc/stb 0 immediately, no ack.
- With WB_DEMUX_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never responds -> wbm_err_o at cycle 10, stb low from cycle 10. Without the macro, stb is still high at cycle 1000.
